multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Main control unit of the multicycle MIPS datapath. It drives the PC-source select and the PC write enables.
//  It sequences fetch, decode, execute, memory and writeback, one state per cycle.
//  Memory states stretch on a ready handshake.
//  Outputs feed the PC mux, the ALU control, the register file, the IR and the memory port.
// PARAMETERS
//  OPW        6   opcode width (instr[31:26])
//  CNTW       32  retired-instruction counter width
// PORTS
//  clk         in   1     rising-edge clock, single domain
//  rst_n       in   1     asynchronous active-low reset
//  opcode      in   OPW   IR[31:26], valid from DECODE onward
//  zero        in   1     ALU zero flag (beq compare)
//  mem_ready   in   1     memory completes the access this cycle
//  PCWrite     out  1     unconditional PC load
//  PCWriteCond out  1     PC load if zero==1
//  PCSource    out  2     0=ALUResult, 1=ALUOut, 2={6'b0,jumpaddress}
//  IorD        out  1     0=PC, 1=ALUOut drives memory address
//  MemRead     out  1     memory read request
//  MemWrite    out  1     memory write request
//  IRWrite     out  1     load instruction register
//  MemtoReg    out  1     1=MDR to register file write data
//  RegDst      out  1     1=rd, 0=rt
//  RegWrite    out  1     register file write enable
//  ALUSrcA     out  1     0=PC, 1=A
//  ALUSrcB     out  2     0=B, 1=const 4, 2=signext imm, 3=signext imm<<2
//  ALUOp       out  2     0=add, 1=sub, 2=funct-decoded
//  illegal_op  out  1     sticky: unsupported opcode decoded
//  instr_count out  CNTW  instructions fetched since reset
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, instr_count=0, every output 0. IDLE->FETCH after one cycle.
//  - Outputs are Moore-decoded from state. Exception: strobes marked (r) are gated by mem_ready.
//  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0.
//    IRWrite(r), PCWrite(r). Stays while mem_ready=0. On mem_ready=1: ->DECODE, instr_count+1 (wraps).
//  - DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0 (branch target into ALUOut). Next state by opcode:
//    0x23/0x2B->MEM_ADDR, 0x00->EXEC_R, 0x04->BRANCH, 0x02->JUMP, 0x08->EXEC_I, other->ILLEGAL.
//  - MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Next: lw->MEM_RD, sw->MEM_WR.
//  - MEM_RD: MemRead=1, IorD=1. Waits on mem_ready, then ->MEM_WB.
//  - MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Then ->FETCH.
//  - MEM_WR: MemWrite=1, IorD=1. Waits on mem_ready, then ->FETCH.
//  - EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUOp=2. Then ->R_WB.
//  - R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Then ->FETCH.
//  - EXEC_I: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Then ->I_WB.
//  - I_WB: RegWrite=1, RegDst=0. Then ->FETCH.
//  - BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1. Then ->FETCH.
//  - JUMP: PCWrite=1, PCSource=2. Then ->FETCH.
//  - ILLEGAL: all strobes 0, illegal_op=1. Absorbing state; only rst_n exits.
//  - PCWrite, PCWriteCond, MemWrite and RegWrite are never asserted in the same cycle.
//  - mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
//  - opcode is sampled only in DECODE and MEM_ADDR. IR is stable there because IRWrite=0.
//  - Latency in cycles (zero wait states): lw 5, sw 4, R/addi 4, beq 3, j 3.
//    Each wait cycle adds 1 to the FETCH or memory states.
//  - Reset mid-instruction aborts immediately. Any in-flight access is dropped and outputs go to 0.
//  - Unused PCSource code 3 is never driven.
// STRUCTURE
//  - Shared package mc_ctrl_pkg holds:
//    - state encoding localparams (4-bit);
//    - opcode constants OP_RTYPE/LW/SW/BEQ/J/ADDI;
//    - PCSRC_ALU/ALUOUT/JUMP and ALUSRCB_* codes.
//  - One sub-module, mc_opcode_class: combinational opcode-to-class decode.
//    Classes: mem, rtype, branch, jump, imm, illegal.
//  - Top holds the state register, the next-state logic, the output decode and instr_count.
// TESTING
//  - Reset then lw (0x23), mem_ready=1 always:
//    states IDLE,FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB. RegWrite=1 and MemtoReg=1 only in cycle 6.
//    instr_count=1.
//  - FETCH with mem_ready low for 3 cycles: MemRead=1 for 4 cycles.
//    IRWrite and PCWrite pulse once, in cycle 4.
//  - beq (0x04), zero=1 then zero=0: BRANCH cycle shows PCWriteCond=1, PCSource=1, ALUOp=1, PCWrite=0.
//  - j (0x02): JUMP cycle shows PCWrite=1, PCSource=2. FETCH follows.
//  - Opcode 0x3F: DECODE goes to ILLEGAL. illegal_op=1 and all strobes 0 for 10 cycles.
//    rst_n pulse clears to IDLE.
//  - rst_n asserted in MEM_WR with mem_ready=0:
//    MemWrite drops to 0 asynchronously, instr_count=0, restart from IDLE.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes,
// supported opcodes, datapath mux select codes and opcode classes.
package mc_ctrl_pkg;

    // 4-bit state codes, kept as named constants so that debug tooling can
    // decode the exposed state value without depending on the enum.
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_FETCH    = 4'd1;
    localparam logic [3:0] ST_DECODE   = 4'd2;
    localparam logic [3:0] ST_MEM_ADDR = 4'd3;
    localparam logic [3:0] ST_MEM_RD   = 4'd4;
    localparam logic [3:0] ST_MEM_WB   = 4'd5;
    localparam logic [3:0] ST_MEM_WR   = 4'd6;
    localparam logic [3:0] ST_EXEC_R   = 4'd7;
    localparam logic [3:0] ST_R_WB     = 4'd8;
    localparam logic [3:0] ST_EXEC_I   = 4'd9;
    localparam logic [3:0] ST_I_WB     = 4'd10;
    localparam logic [3:0] ST_BRANCH   = 4'd11;
    localparam logic [3:0] ST_JUMP     = 4'd12;
    localparam logic [3:0] ST_ILLEGAL  = 4'd13;

    typedef enum logic [3:0] {
        IDLE     = ST_IDLE,
        FETCH    = ST_FETCH,
        DECODE   = ST_DECODE,
        MEM_ADDR = ST_MEM_ADDR,
        MEM_RD   = ST_MEM_RD,
        MEM_WB   = ST_MEM_WB,
        MEM_WR   = ST_MEM_WR,
        EXEC_R   = ST_EXEC_R,
        R_WB     = ST_R_WB,
        EXEC_I   = ST_EXEC_I,
        I_WB     = ST_I_WB,
        BRANCH   = ST_BRANCH,
        JUMP     = ST_JUMP,
        ILLEGAL  = ST_ILLEGAL
    } state_t;

    // Supported opcodes (instr[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // PC source mux; code 3 is unused and never driven.
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // ALU B operand mux.
    localparam logic [1:0] ALUSRCB_B       = 2'd0;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'd1;
    localparam logic [1:0] ALUSRCB_IMM     = 2'd2;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'd3;

    // ALU operation request to the ALU control block.
    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    typedef enum logic [2:0] {
        CLS_MEM,
        CLS_RTYPE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_IMM,
        CLS_ILLEGAL
    } opclass_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multicycle control unit (master) and the datapath
// (slave). The control unit produces every strobe; the datapath returns the
// opcode, the ALU zero flag and the memory ready indication.
// Handshake: in FETCH, MEM_RD and MEM_WR the control unit holds its memory
// request (MemRead or MemWrite) high every cycle until the memory raises
// mem_ready; the access completes in the cycle where both are high, and
// mem_ready has no meaning in any other state.
interface multicycle_control_fsm_if #(
    parameter int OPW  = 6,
    parameter int CNTW = 32
) ();
    logic [OPW-1:0]       opcode;
    logic                 zero;
    logic                 mem_ready;
    logic                 PCWrite;
    logic                 PCWriteCond;
    logic [1:0]           PCSource;
    logic                 IorD;
    logic                 MemRead;
    logic                 MemWrite;
    logic                 IRWrite;
    logic                 MemtoReg;
    logic                 RegDst;
    logic                 RegWrite;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ALUOp;
    logic                 illegal_op;
    logic [CNTW-1:0]      instr_count;
    mc_ctrl_pkg::state_t  state_dbg;

    modport master (
        input  opcode, zero, mem_ready,
        output PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               illegal_op, instr_count, state_dbg
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               illegal_op, instr_count, state_dbg
    );
endinterface

// File: rtl/mc_opcode_class.sv
// Combinational opcode-to-class decode used by the DECODE state.
module mc_opcode_class
    import mc_ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] opcode,
    output opclass_t       cls
);

    // Map each supported opcode onto its execution class; anything else is illegal.
    always_comb begin
        cls = CLS_ILLEGAL;
        if (opcode == OPW'(OP_LW) || opcode == OPW'(OP_SW)) begin
            cls = CLS_MEM;
        end else if (opcode == OPW'(OP_RTYPE)) begin
            cls = CLS_RTYPE;
        end else if (opcode == OPW'(OP_BEQ)) begin
            cls = CLS_BRANCH;
        end else if (opcode == OPW'(OP_J)) begin
            cls = CLS_JUMP;
        end else if (opcode == OPW'(OP_ADDI)) begin
            cls = CLS_IMM;
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control unit of the multicycle MIPS datapath. One state per cycle;
// FETCH and the memory access states stretch until mem_ready. Outputs are
// decoded from state only, except IRWrite/PCWrite in FETCH which fire in the
// cycle the instruction word actually arrives.
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OPW  = 6,
    parameter int CNTW = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_control_fsm_if.master  bus
);

    state_t          state;
    state_t          state_nxt;
    opclass_t        cls;
    logic [CNTW-1:0] count;

    mc_opcode_class #(.OPW(OPW)) u_opcode_class (
        .opcode (bus.opcode),
        .cls    (cls)
    );

    // State register; reset aborts any in-flight access immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; mem_ready only matters in FETCH, MEM_RD and MEM_WR.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = FETCH;
            FETCH:    if (bus.mem_ready) state_nxt = DECODE;
            DECODE: begin
                case (cls)
                    CLS_MEM:    state_nxt = MEM_ADDR;
                    CLS_RTYPE:  state_nxt = EXEC_R;
                    CLS_BRANCH: state_nxt = BRANCH;
                    CLS_JUMP:   state_nxt = JUMP;
                    CLS_IMM:    state_nxt = EXEC_I;
                    default:    state_nxt = ILLEGAL;
                endcase
            end
            MEM_ADDR: state_nxt = (bus.opcode == OPW'(OP_LW)) ? MEM_RD : MEM_WR;
            MEM_RD:   if (bus.mem_ready) state_nxt = MEM_WB;
            MEM_WB:   state_nxt = FETCH;
            MEM_WR:   if (bus.mem_ready) state_nxt = FETCH;
            EXEC_R:   state_nxt = R_WB;
            R_WB:     state_nxt = FETCH;
            EXEC_I:   state_nxt = I_WB;
            I_WB:     state_nxt = FETCH;
            BRANCH:   state_nxt = FETCH;
            JUMP:     state_nxt = FETCH;
            ILLEGAL:  state_nxt = ILLEGAL;
            default:  state_nxt = IDLE;
        endcase
    end

    // Moore output decode; every strobe defaults low so unlisted ones stay 0.
    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.PCSource    = PCSRC_ALU;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = ALUSRCB_B;
        bus.ALUOp       = ALUOP_ADD;
        bus.illegal_op  = 1'b0;
        case (state)
            FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = ALUSRCB_FOUR;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
            end
            DECODE: begin
                bus.ALUSrcB = ALUSRCB_IMM_SH2;
            end
            MEM_ADDR, EXEC_I: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = ALUSRCB_IMM;
            end
            MEM_RD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            MEM_WB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            MEM_WR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            EXEC_R: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = ALUOP_FUNCT;
            end
            R_WB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
            end
            I_WB: begin
                bus.RegWrite = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = ALUOP_SUB;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = PCSRC_ALUOUT;
            end
            JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = PCSRC_JUMP;
            end
            ILLEGAL: begin
                bus.illegal_op = 1'b1;
            end
            default: ;
        endcase
    end

    // Count instructions as they are fetched; wraps at the counter width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (state == FETCH && bus.mem_ready) begin
            count <= count + CNTW'(1);
        end
    end

    assign bus.instr_count = count;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: a driver walks whole instructions with
// random wait states and pushes the expected control word for every cycle;
// a monitor pops and compares at each falling edge.
module tb_multicycle_control_fsm;
    import mc_ctrl_pkg::*;

    localparam int W = 49;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    multicycle_control_fsm_if #(.OPW(6), .CNTW(32)) bus ();

    multicycle_control_fsm #(.OPW(6), .CNTW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock
    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_checks = 0;
    int           n_pass = 0;
    logic [31:0]  model_count = 32'd0;
    logic [5:0]   legal_ops[6];

    // Control word fields in order:
    // PCWrite PCWriteCond PCSource IorD MemRead MemWrite IRWrite MemtoReg
    // RegDst RegWrite ALUSrcA ALUSrcB ALUOp illegal_op
    function automatic logic [16:0] mk(input logic pcw, input logic pcwc,
                                       input logic [1:0] pcs, input logic iord,
                                       input logic mr, input logic mw,
                                       input logic irw, input logic m2r,
                                       input logic rd, input logic rw,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [1:0] aop, input logic ill);
        return {pcw, pcwc, pcs, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ill};
    endfunction

    function automatic logic [W-1:0] act_vec();
        return {bus.PCWrite, bus.PCWriteCond, bus.PCSource, bus.IorD,
                bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg,
                bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
                bus.ALUOp, bus.illegal_op, bus.instr_count};
    endfunction

    // Expected control words per instruction phase, straight from the state table.
    function automatic logic [16:0] v_fetch(input logic rdy);
        return mk(rdy, 0, 2'd0, 0, 1, 0, rdy, 0, 0, 0, 0, 2'd1, 2'd0, 0);
    endfunction
    localparam logic [16:0] V_IDLE   = 17'd0;
    localparam logic [16:0] V_DECODE = {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0};
    localparam logic [16:0] V_MADDR  = {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0};
    localparam logic [16:0] V_MRD    = {1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    localparam logic [16:0] V_MWB    = {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
    localparam logic [16:0] V_MWR    = {1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    localparam logic [16:0] V_EXR    = {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 1'b0};
    localparam logic [16:0] V_RWB    = {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
    localparam logic [16:0] V_EXI    = {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0};
    localparam logic [16:0] V_IWB    = {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
    localparam logic [16:0] V_BR     = {1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0};
    localparam logic [16:0] V_JMP    = {1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    localparam logic [16:0] V_ILL    = {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1};

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // scoreboard monitor: one expected word per clock while out of reset
    always @(negedge clk) begin : monitor
        logic [W-1:0] e;
        string        t;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, act_vec(), e);
        end
    end

    // drive one cycle of inputs, record its expected outputs, advance to next cycle
    task automatic drive_cycle(input string tag, input logic [16:0] ctl,
                               input logic [5:0] opc, input logic rdy);
        bus.opcode    = opc;
        bus.mem_ready = rdy;
        bus.zero      = 1'($urandom_range(0, 1));
        exp_q.push_back({ctl, model_count});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_phase(input int waits);
        for (int w = 0; w <= waits; w++) begin
            drive_cycle("fetch", v_fetch(w == waits), 6'($urandom_range(0, 63)), w == waits);
        end
        model_count = model_count + 32'd1;
    endtask

    task automatic mem_phase(input string tag, input logic [16:0] ctl,
                             input logic [5:0] opc, input int waits);
        for (int w = 0; w <= waits; w++) begin
            drive_cycle(tag, ctl, opc, w == waits);
        end
    endtask

    task automatic run_instr(input logic [5:0] opc, input int wf, input int wm);
        fetch_phase(wf);
        drive_cycle("decode", V_DECODE, opc, 1'($urandom_range(0, 1)));
        case (opc)
            OP_LW: begin
                drive_cycle("lw_addr", V_MADDR, opc, 1'($urandom_range(0, 1)));
                mem_phase("lw_rd", V_MRD, opc, wm);
                drive_cycle("lw_wb", V_MWB, opc, 1'($urandom_range(0, 1)));
            end
            OP_SW: begin
                drive_cycle("sw_addr", V_MADDR, opc, 1'($urandom_range(0, 1)));
                mem_phase("sw_wr", V_MWR, opc, wm);
            end
            OP_RTYPE: begin
                drive_cycle("r_exec", V_EXR, opc, 1'($urandom_range(0, 1)));
                drive_cycle("r_wb", V_RWB, opc, 1'($urandom_range(0, 1)));
            end
            OP_ADDI: begin
                drive_cycle("i_exec", V_EXI, opc, 1'($urandom_range(0, 1)));
                drive_cycle("i_wb", V_IWB, opc, 1'($urandom_range(0, 1)));
            end
            OP_BEQ: drive_cycle("branch", V_BR, opc, 1'($urandom_range(0, 1)));
            OP_J:   drive_cycle("jump", V_JMP, opc, 1'($urandom_range(0, 1)));
            default: begin
                for (int i = 0; i < 10; i++) begin
                    drive_cycle("illegal", V_ILL, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
                end
            end
        endcase
    endtask

    // async reset: outputs and counter must clear without waiting for a clock
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_outputs"}, act_vec(), '0);
        model_count = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_cycle("idle", V_IDLE, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    endtask

    function automatic logic is_legal(input logic [5:0] opc);
        for (int i = 0; i < 6; i++) if (legal_ops[i] == opc) return 1'b1;
        return 1'b0;
    endfunction

    initial begin : driver
        logic [5:0] opc;
        legal_ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI};
        bus.opcode = 6'd0;
        bus.mem_ready = 1'b0;
        bus.zero = 1'b0;
        #2;
        do_reset("reset_init");

        // directed instructions
        run_instr(OP_LW, 0, 0);
        run_instr(OP_ADDI, 3, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_J, 0, 0);
        run_instr(OP_RTYPE, 1, 0);
        run_instr(OP_SW, 0, 2);
        run_instr(OP_LW, 2, 3);

        // random legal instruction stream
        for (int i = 0; i < 40; i++) begin
            run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // illegal opcode 0x3F, then a random illegal one
        run_instr(6'h3F, 0, 0);
        do_reset("reset_illegal");
        run_instr(OP_J, 1, 0);
        opc = 6'($urandom_range(0, 63));
        while (is_legal(opc)) opc = 6'($urandom_range(0, 63));
        run_instr(opc, $urandom_range(0, 2), 0);
        do_reset("reset_illegal2");

        // reset in the middle of a stalled store
        run_instr(OP_ADDI, 0, 0);
        fetch_phase(0);
        drive_cycle("decode", V_DECODE, OP_SW, 1'b0);
        drive_cycle("sw_addr", V_MADDR, OP_SW, 1'b0);
        drive_cycle("sw_wr", V_MWR, OP_SW, 1'b0);
        bus.mem_ready = 1'b0;
        exp_q.push_back({V_MWR, model_count});
        tag_q.push_back("sw_wr_stall");
        @(negedge clk);
        #1;
        do_reset("reset_mid_sw");
        check("instr_count_after_reset", {17'd0, bus.instr_count}, '0);

        for (int i = 0; i < 10; i++) begin
            run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 2));
        end

        @(posedge clk);
        #1;
        check("scoreboard_drained", W'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
